// File: rtl/uart_tx_frame_serializer.sv
// UART transmit serializer: frames a parallel word with start, data, optional parity and 1/2 stop bits.
// Each line level is held for one BIT_TICK period; configuration is latched with the word.
module uart_tx_frame_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  MSB_FIRST,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic                  BIT_TICK,
    output logic                  TX_OUT,
    output logic                  ACCEPT,
    output logic                  BUSY,
    output logic                  FRAME_DONE
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    msb_q, msb_d;
    logic                    par_en_q, par_en_d;
    logic                    par_q, par_d;
    logic                    stop2_q, stop2_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    take_s;
    logic                    done_s;
    logic [CW-1:0]           sel_s;

    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // Next-state, capture and next line level
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        data_d   = data_q;
        msb_d    = msb_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        stop2_d  = stop2_q;
        take_s   = 1'b0;
        done_s   = 1'b0;
        tx_d     = 1'b1;
        busy_d   = 1'b0;
        sel_s    = '0;
        if (BIT_TICK) begin
            case (state_q)
                S_IDLE: take_s = DATA_VALID;
                S_START: begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
                S_DATA: begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                    end else begin
                        idx_d = idx_q + CW'(1);
                    end
                end
                S_PARITY: state_d = S_STOP1;
                S_STOP1: begin
                    if (stop2_q) begin
                        state_d = S_STOP2;
                    end else begin
                        done_s  = 1'b1;
                        take_s  = DATA_VALID;
                        state_d = S_IDLE;
                    end
                end
                S_STOP2: begin
                    done_s  = 1'b1;
                    take_s  = DATA_VALID;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
            // A capture at frame end overrides the return to idle: no gap bit between frames
            if (take_s) begin
                data_d   = P_DATA;
                msb_d    = MSB_FIRST;
                par_en_d = PAR_EN;
                par_d    = parity_bit(P_DATA, PAR_TYP);
                stop2_d  = STOP2;
                idx_d    = '0;
                state_d  = S_START;
            end else begin
                data_d = data_q;
            end
        end else begin
            state_d = state_q;
        end

        sel_s = msb_d ? (LAST_IDX - idx_d) : idx_d;
        case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[sel_s];
            S_PARITY: tx_d = par_d;
            S_STOP1:  tx_d = 1'b1;
            S_STOP2:  tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            data_q   <= '0;
            msb_q    <= 1'b0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            msb_q    <= msb_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            stop2_q  <= stop2_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    // Handshake pulses are decoded in the capture cycle; reset masks them at once
    assign ACCEPT     = take_s & ~RST;
    assign FRAME_DONE = done_s & ~RST;
    assign TX_OUT     = tx_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Scoreboard bench for uart_tx_frame_serializer: driver pushes reference frames, a monitor checks the line.
module tb_uart_tx_frame_serializer;
    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid, msb_first, par_en, par_typ, stop2, bit_tick;
    logic       tx_out, accept, busy, frame_done;
    logic [4:0] d5;
    logic       v5, tx5, acc5, busy5, done5;

    int     n_checks = 0;
    int     n_errors = 0;
    int     tick_mode = 0;
    int     tick_cnt = 0;
    frame_t sb[$];
    frame_t cur;
    int     k = 0;
    bit     active = 1'b0;

    uart_tx_frame_serializer #(.DATA_WIDTH(8)) u_dut (
        .CLK(clk), .RST(rst), .P_DATA(p_data), .DATA_VALID(data_valid),
        .MSB_FIRST(msb_first), .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
        .BIT_TICK(bit_tick), .TX_OUT(tx_out), .ACCEPT(accept), .BUSY(busy),
        .FRAME_DONE(frame_done)
    );

    uart_tx_frame_serializer #(.DATA_WIDTH(5)) u_dut5 (
        .CLK(clk), .RST(rst), .P_DATA(d5), .DATA_VALID(v5),
        .MSB_FIRST(1'b0), .PAR_EN(1'b1), .PAR_TYP(1'b0), .STOP2(1'b0),
        .BIT_TICK(1'b1), .TX_OUT(tx5), .ACCEPT(acc5), .BUSY(busy5),
        .FRAME_DONE(done5)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: list of line levels from start bit to last stop bit
    function automatic frame_t model(input logic [8:0] d, input int w, input bit msb,
                                     input bit pe, input bit pt, input bit s2);
        frame_t f;
        int n;
        logic [8:0] m;
        m = d & ((9'd1 << w) - 9'd1);
        f.bits = '0;
        f.bits[0] = 1'b0;
        for (int i = 0; i < w; i++) f.bits[1 + i] = msb ? m[w - 1 - i] : m[i];
        n = 1 + w;
        if (pe) begin
            f.bits[n] = ($countones(m) % 2 == 1) ^ pt;
            n++;
        end
        f.bits[n] = 1'b1;
        n++;
        if (s2) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.len = n;
        return f;
    endfunction

    // Bit-period strobe generator
    initial begin
        bit_tick = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tick_mode)
                0: bit_tick = 1'b1;
                1: begin
                    tick_cnt = (tick_cnt + 1) % 4;
                    bit_tick = (tick_cnt == 0);
                end
                default: bit_tick = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: compares line, BUSY, ACCEPT and FRAME_DONE every cycle
    initial begin
        bit final_tick, exp_acc;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
                sb.delete();
            end else begin
                final_tick = active && bit_tick && (k == cur.len - 1);
                exp_acc = data_valid && bit_tick && (!active || final_tick);
                check("accept", accept, exp_acc);
                if (active) begin
                    check("tx_bit", tx_out, cur.bits[k]);
                    check("busy", busy, 1);
                    check("frame_done", frame_done, final_tick);
                    if (bit_tick) begin
                        k++;
                        if (k == cur.len) active = 1'b0;
                    end
                end else begin
                    check("tx_idle", tx_out, 1);
                    check("busy_idle", busy, 0);
                    check("done_idle", frame_done, 0);
                end
                if (accept) begin
                    if (sb.size() == 0) begin
                        check("sb_empty_on_accept", 0, 1);
                    end else begin
                        cur = sb.pop_front();
                        k = 0;
                        active = 1'b1;
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit msb, input bit pe, input bit pt,
                        input bit s2, input int gap);
        bit got;
        @(posedge clk);
        #1;
        p_data = d; msb_first = msb; par_en = pe; par_typ = pt; stop2 = s2;
        sb.push_back(model({1'b0, d}, 8, msb, pe, pt, s2));
        data_valid = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 4000 && !got; c++) begin
            @(negedge clk);
            got = accept;
        end
        if (!got) begin
            check("accept_timeout", 0, 1);
            void'(sb.pop_back());
            data_valid = 1'b0;
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            data_valid = 1'b0;
            p_data = 8'($urandom); msb_first = 1'($urandom); par_en = 1'($urandom);
            par_typ = 1'($urandom); stop2 = 1'($urandom);
        end
    endtask

    initial begin
        frame_t f5;
        bit drained;
        rst = 1'b0; data_valid = 1'b0; p_data = 8'h00; msb_first = 1'b0;
        par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; d5 = 5'h00; v5 = 1'b0;
        #1 rst = 1'b1;
        data_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_tx", tx_out, 1);
        check("rst_busy", busy, 0);
        check("rst_accept", accept, 0);
        check("rst_done", frame_done, 0);
        data_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed frames
        send(8'hA5, 0, 0, 0, 0, 3);
        send(8'hA5, 1, 1, 1, 1, 3);
        tick_mode = 1;
        send(8'h03, 0, 1, 0, 0, 3);
        tick_mode = 0;
        send(8'h11, 0, 0, 0, 0, 0);
        send(8'h22, 0, 0, 0, 0, 3);

        // Reset during data bit 3
        send(8'hA5, 0, 0, 0, 0, 1);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx", tx_out, 1);
        check("midrst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(8'h5C, 1, 1, 0, 1, 2);

        // Five-bit instance
        @(posedge clk);
        #1 v5 = 1'b1; d5 = 5'h1F;
        f5 = model(9'h1F, 5, 0, 1, 0, 0);
        @(negedge clk);
        check("w5_accept", acc5, 1);
        @(posedge clk);
        #1 v5 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("w5_tx", tx5, f5.bits[i]);
            check("w5_busy", busy5, 1);
            check("w5_done", done5, (i == 7));
        end
        @(negedge clk);
        check("w5_idle_busy", busy5, 0);
        check("w5_idle_tx", tx5, 1);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) tick_mode = $urandom_range(0, 2);
            send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 3));
        end
        @(posedge clk);
        #1 data_valid = 1'b0;

        drained = 1'b0;
        for (int c = 0; c < 5000 && !drained; c++) begin
            @(negedge clk);
            drained = !active && (sb.size() == 0);
        end
        check("drain", drained, 1);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
